// File: rtl/get_reg.sv
// RISC-V integer register number <-> 4-char ASCII ABI name lookup for trace/dump printing.
// Forward and reverse paths are independent, each with one registered cycle of latency.
module get_reg #(
  parameter int IDX_W    = 6,
  parameter bit FP_ALIAS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_valid,
  input  logic [IDX_W-1:0] fwd_idx,
  output logic             fwd_rvalid,
  output logic [31:0]      fwd_name,
  output logic             fwd_err,
  input  logic             rev_valid,
  input  logic [31:0]      rev_name,
  output logic             rev_rvalid,
  output logic [4:0]       rev_idx,
  output logic             rev_hit
);

  localparam logic [31:0] NAME_FP   = 32'h0000_6670;
  localparam logic [31:0] NAME_UNKN = 32'h0000_003F;

  // Canonical table; x8 is always "s0" here, the fp alias is layered on top.
  function automatic logic [31:0] abi_name(input logic [4:0] i);
    logic [31:0] n;
    n = 32'h0;
    case (i) inside
      5'd0:            n = 32'h7A65_726F;
      5'd1:            n = 32'h0000_7261;
      5'd2:            n = 32'h0000_7370;
      5'd3:            n = 32'h0000_6770;
      5'd4:            n = 32'h0000_7470;
      [5'd5:5'd7]:     n = 32'h0000_7430 + 32'(i - 5'd5);
      5'd8:            n = 32'h0000_7330;
      5'd9:            n = 32'h0000_7331;
      [5'd10:5'd17]:   n = 32'h0000_6130 + 32'(i - 5'd10);
      [5'd18:5'd25]:   n = 32'h0000_7332 + 32'(i - 5'd18);
      5'd26:           n = 32'h0073_3130;
      5'd27:           n = 32'h0073_3131;
      [5'd28:5'd31]:   n = 32'h0000_7433 + 32'(i - 5'd28);
      default:         n = 32'h0;
    endcase
    return n;
  endfunction

  // Returns {hit, index}; accepts both "s0" and "fp" for x8 regardless of FP_ALIAS.
  function automatic logic [5:0] abi_index(input logic [31:0] name);
    logic [5:0] r;
    r = 6'd0;
    for (int k = 0; k < 32; k++) begin
      if (name == abi_name(5'(k))) r = {1'b1, 5'(k)};
    end
    if (name == NAME_FP) r = {1'b1, 5'd8};
    return r;
  endfunction

  logic        w_fwd_oob;
  logic [4:0]  w_fwd_sel;
  logic [31:0] w_fwd_name;
  logic [5:0]  w_rev_res;

  assign w_fwd_oob  = |(fwd_idx >> 5);
  assign w_fwd_sel  = fwd_idx[4:0];
  assign w_fwd_name = w_fwd_oob                      ? NAME_UNKN :
                      (FP_ALIAS && w_fwd_sel == 5'd8) ? NAME_FP   :
                      abi_name(w_fwd_sel);
  assign w_rev_res  = abi_index(rev_name);

  logic        r_fwd_rvalid;
  logic [31:0] r_fwd_name;
  logic        r_fwd_err;
  logic        r_rev_rvalid;
  logic [4:0]  r_rev_idx;
  logic        r_rev_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_rvalid <= 1'b0;
      r_fwd_name   <= 32'h0;
      r_fwd_err    <= 1'b0;
    end else begin
      r_fwd_rvalid <= fwd_valid;
      if (fwd_valid) begin
        r_fwd_name <= w_fwd_name;
        r_fwd_err  <= w_fwd_oob;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rev_rvalid <= 1'b0;
      r_rev_idx    <= 5'd0;
      r_rev_hit    <= 1'b0;
    end else begin
      r_rev_rvalid <= rev_valid;
      if (rev_valid) begin
        r_rev_idx <= w_rev_res[4:0];
        r_rev_hit <= w_rev_res[5];
      end
    end
  end

  assign fwd_rvalid = r_fwd_rvalid;
  assign fwd_name   = r_fwd_name;
  assign fwd_err    = r_fwd_err;
  assign rev_rvalid = r_rev_rvalid;
  assign rev_idx    = r_rev_idx;
  assign rev_hit    = r_rev_hit;

endmodule

// File: tb/tb_get_reg.sv
// Directed bench for get_reg: reset, forward sweep, out-of-range, fp alias,
// reverse hits/misses, concurrent requests and a forward->reverse round trip.
module tb_get_reg;

  logic        clk;
  logic        rst;
  logic        fwd_valid;
  logic [5:0]  fwd_idx;
  logic        rev_valid;
  logic [31:0] rev_name;

  logic        fwd_rvalid, fwd_err, rev_rvalid, rev_hit;
  logic [31:0] fwd_name;
  logic [4:0]  rev_idx;

  logic        fp_fwd_rvalid, fp_fwd_err, fp_rev_rvalid, fp_rev_hit;
  logic [31:0] fp_fwd_name;
  logic [4:0]  fp_rev_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_name [32];

  get_reg #(.IDX_W(6), .FP_ALIAS(1'b0)) dut (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx),
    .fwd_rvalid(fwd_rvalid), .fwd_name(fwd_name), .fwd_err(fwd_err),
    .rev_valid(rev_valid), .rev_name(rev_name),
    .rev_rvalid(rev_rvalid), .rev_idx(rev_idx), .rev_hit(rev_hit)
  );

  get_reg #(.IDX_W(6), .FP_ALIAS(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx),
    .fwd_rvalid(fp_fwd_rvalid), .fwd_name(fp_fwd_name), .fwd_err(fp_fwd_err),
    .rev_valid(rev_valid), .rev_name(rev_name),
    .rev_rvalid(fp_rev_rvalid), .rev_idx(fp_rev_idx), .rev_hit(fp_rev_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".fwd_rvalid"}, 32'(fwd_rvalid), 32'd0);
    chk({tag, ".fwd_name"},   fwd_name,        32'd0);
    chk({tag, ".fwd_err"},    32'(fwd_err),    32'd0);
    chk({tag, ".rev_rvalid"}, 32'(rev_rvalid), 32'd0);
    chk({tag, ".rev_idx"},    32'(rev_idx),    32'd0);
    chk({tag, ".rev_hit"},    32'(rev_hit),    32'd0);
  endtask

  task automatic rev_req(input string tag, input logic [31:0] name,
                         input logic [4:0] e_idx, input logic e_hit);
    @(negedge clk);
    rev_valid = 1'b1;
    rev_name  = name;
    step();
    chk({tag, ".rvalid"}, 32'(rev_rvalid), 32'd1);
    chk({tag, ".idx"},    32'(rev_idx),    32'(e_idx));
    chk({tag, ".hit"},    32'(rev_hit),    32'(e_hit));
  endtask

  initial begin
    logic [31:0] got;
    exp_name = '{32'h7A65726F, 32'h00007261, 32'h00007370, 32'h00006770,
                 32'h00007470, 32'h00007430, 32'h00007431, 32'h00007432,
                 32'h00007330, 32'h00007331, 32'h00006130, 32'h00006131,
                 32'h00006132, 32'h00006133, 32'h00006134, 32'h00006135,
                 32'h00006136, 32'h00006137, 32'h00007332, 32'h00007333,
                 32'h00007334, 32'h00007335, 32'h00007336, 32'h00007337,
                 32'h00007338, 32'h00007339, 32'h00733130, 32'h00733131,
                 32'h00007433, 32'h00007434, 32'h00007435, 32'h00007436};

    rst = 1'b1; fwd_valid = 1'b0; fwd_idx = '0; rev_valid = 1'b0; rev_name = '0;
    step(); step();
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    step();
    check_all_zero("idle");

    // Reset asserted while a request is presented: it must be dropped.
    @(negedge clk);
    fwd_valid = 1'b1; fwd_idx = 6'd2; rev_valid = 1'b1; rev_name = 32'h0000_7261;
    #2 rst = 1'b1;
    step();
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0; fwd_valid = 1'b0; rev_valid = 1'b0;
    step();
    check_all_zero("rst_after");

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      fwd_valid = 1'b1; fwd_idx = 6'(i);
      step();
      chk($sformatf("sweep%0d.rvalid", i), 32'(fwd_rvalid), 32'd1);
      chk($sformatf("sweep%0d.name", i),   fwd_name,        exp_name[i]);
      chk($sformatf("sweep%0d.err", i),    32'(fwd_err),    32'd0);
    end
    chk("spot.idx31_fp", fp_fwd_name, 32'h0000_7436);

    @(negedge clk); fwd_idx = 6'd40;
    step();
    chk("oob.name",   fwd_name,        32'h0000_003F);
    chk("oob.err",    32'(fwd_err),    32'd1);
    chk("oob.rvalid", 32'(fwd_rvalid), 32'd1);
    @(negedge clk); fwd_valid = 1'b0; fwd_idx = 6'd1;
    step();
    chk("hold.rvalid", 32'(fwd_rvalid), 32'd0);
    chk("hold.name",   fwd_name,        32'h0000_003F);
    chk("hold.err",    32'(fwd_err),    32'd1);
    @(negedge clk); fwd_valid = 1'b1; fwd_idx = 6'd63;
    step();
    chk("oob63.err",   32'(fwd_err),    32'd1);
    chk("oob63.name",  fwd_name,        32'h0000_003F);

    @(negedge clk); fwd_valid = 1'b1; fwd_idx = 6'd8;
    step();
    chk("x8.s0",      fwd_name,        32'h0000_7330);
    chk("x8.fp",      fp_fwd_name,     32'h0000_6670);
    chk("x8.err",     32'(fwd_err),    32'd0);
    @(negedge clk); fwd_valid = 1'b0;

    rev_req("rev_s0", 32'h0000_7330, 5'd8, 1'b1);
    rev_req("rev_fp", 32'h0000_6670, 5'd8, 1'b1);
    chk("rev_fp.alias_inst", 32'(fp_rev_idx), 32'd8);
    rev_req("rev_a7",   32'h0000_6137, 5'd17, 1'b1);
    rev_req("rev_x5",   32'h0000_7835, 5'd0,  1'b0);
    rev_req("rev_s11",  32'h0073_3131, 5'd27, 1'b1);
    rev_req("rev_pad",  32'h0100_7261, 5'd0,  1'b0);
    rev_req("rev_zero", 32'h7A65_726F, 5'd0,  1'b1);
    rev_req("rev_RA",   32'h0000_5241, 5'd0,  1'b0);
    rev_req("rev_t6",   32'h0000_7436, 5'd31, 1'b1);
    @(negedge clk); rev_valid = 1'b0; rev_name = 32'h0000_7261;
    step();
    chk("rev_hold.rvalid", 32'(rev_rvalid), 32'd0);
    chk("rev_hold.idx",    32'(rev_idx),    32'd31);
    chk("rev_hold.hit",    32'(rev_hit),    32'd1);

    @(negedge clk);
    fwd_valid = 1'b1; fwd_idx = 6'd31; rev_valid = 1'b1; rev_name = 32'h0000_7436;
    step();
    chk("both.fwd_rvalid", 32'(fwd_rvalid), 32'd1);
    chk("both.rev_rvalid", 32'(rev_rvalid), 32'd1);
    chk("both.fwd_name",   fwd_name,        32'h0000_7436);
    chk("both.rev_idx",    32'(rev_idx),    32'd31);
    chk("both.rev_hit",    32'(rev_hit),    32'd1);
    @(negedge clk); fwd_valid = 1'b0; rev_valid = 1'b0;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      fwd_valid = 1'b1; fwd_idx = 6'(i); rev_valid = 1'b0;
      step();
      got = fwd_name;
      @(negedge clk);
      fwd_valid = 1'b0; rev_valid = 1'b1; rev_name = got;
      step();
      chk($sformatf("trip%0d.idx", i), 32'(rev_idx), 32'(i));
      chk($sformatf("trip%0d.hit", i), 32'(rev_hit), 32'd1);
    end
    @(negedge clk); rev_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
